uc_control: RTL and testbench
=============================

# uc_control

Sequencing control unit for the single-cycle microcontroller datapath. It decodes the 6-bit `Opcode` and the registered zero flag `z` into `s_inc`, `s_inm`, `we3`, `wez` and `Op[2:0]`. It also owns run/halt/fault sequencing: it holds the datapath in reset while idle, stops on a HALT instruction, traps illegal opcodes and, optionally, a watchdog timeout. It exposes a retired-instruction counter for bench and debug use.

## Interface
- `WDT_LIMIT`, default 1023: maximum RUN cycles before a watchdog fault. Only meaningful with the watchdog compiled in.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled each cycle in IDLE, HALTED and FAULT.
- `Opcode`  in  6  instruction bits [15:10] from program memory.
- `z`  in  1  registered zero flag from the datapath.
- `s_inc`  out  1  1 selects PC+1; 0 selects the jump target, instruction bits [9:0].
- `s_inm`  out  1  1 selects immediate bits [11:4] for the register-file write data.
- `we3`  out  1  register-file write enable.
- `wez`  out  1  zero-flag write enable.
- `Op`  out  3  ALU operation.
- `dp_reset`  out  1  drives the datapath `reset`; holds PC=0 and z=0.
- `busy`  out  1  state==RUN.
- `halted`  out  1  state==HALTED.
- `fault_cause`  out  2  00 none, 01 illegal opcode, 10 watchdog.
- `icount`  out  16  retired-instruction count, saturating.

## Operation
States: IDLE, RUN, HALTED, FAULT. Reset enters IDLE.

Instruction decode, active only in RUN (x = don't care; these bits overlap the register/immediate fields):
- `1ooo xx` ALU: `Op`=Opcode[4:2], `we3`=1, `wez`=1, `s_inm`=0, `s_inc`=1.
- `0000xx` LI: `we3`=1, `s_inm`=1, `wez`=0, `s_inc`=1.
- `000100` J: `s_inc`=0.
- `000101` JZ: `s_inc`=!z.
- `000110` JNZ: `s_inc`=z.
- `000111` HALT: `s_inc`=0, no writes. The assembler encodes the halt's own address in [9:0], so the PC self-loops.
- `001xxx`, `01xxxx`: illegal.

Outputs outside a RUN decode:
- Default outputs are `s_inc`=1, `s_inm`=0, `we3`=0, `wez`=0, `Op`=000.
- In IDLE and FAULT, `dp_reset`=1 and the default outputs apply.
- In HALTED, `dp_reset`=0, `s_inc`=0, `we3`=`wez`=0, so the PC self-loops on HALT.

Transitions:
- IDLE→RUN on `start`=1. This clears `icount`, the watchdog counter and `fault_cause`.
- RUN→HALTED on the HALT opcode.
- RUN→FAULT on an illegal opcode (`fault_cause`=01). Writes for that cycle are suppressed.
- HALTED→IDLE and FAULT→IDLE on `start`=1. `fault_cause` holds its value until the next IDLE→RUN transition.
- In-RUN priority: watchdog > illegal > HALT > normal.

`icount`:
- Increments on each RUN cycle that executes a legal, non-HALT instruction.
- Saturates at 16'hFFFF; no wrap.

## Timing
- Decode is combinational from `Opcode`, `z` and the state, with zero latency. The datapath executes the instruction at the same edge it is decoded.
- State, `icount`, the watchdog counter and `fault_cause` are registered.
- Reset values: state=IDLE, `dp_reset`=1, `busy`=0, `halted`=0, `fault_cause`=00, `icount`=0, `s_inc`=1, all other outputs 0.
- `start` high in cycle n (IDLE) gives RUN in cycle n+1 with `dp_reset`=0. PC=0 is executed in cycle n+1.
- HALT decoded in cycle n gives `halted`=1 from cycle n+1.
- `reset` asserted mid-RUN gives IDLE on the next edge. No write occurs during the reset cycle, because outputs are gated when `reset`=1.
- `start` held high continuously in HALTED gives IDLE, then RUN on consecutive cycles, i.e. a restart.

## Configuration
- `UC_WATCHDOG_EN` defined:
  - A RUN-cycle counter is compiled in, cleared on IDLE→RUN and incremented each RUN cycle.
  - In the RUN cycle where the count equals `WDT_LIMIT`, all writes are suppressed, `s_inc`=1, and the next state is FAULT with `fault_cause`=10.
  - At most `WDT_LIMIT` instructions execute per run.
- Not defined: no counter logic exists, RUN is unbounded, and `fault_cause` never reads 10.

## Test plan
- Reset, then `start` pulse; program LI 5→R1, LI 5→R2, ALU sub R1,R2→R3, JZ to 8, …, HALT at 8. Required: `we3`/`wez` high on the ALU cycle, `s_inc`=0 on JZ with z=1, `halted`=1 after HALT, `icount`=4.
- JNZ with z=1 gives `s_inc`=1; JZ with z=0 gives `s_inc`=1; J always gives `s_inc`=0.
- Opcode 010011 at address 2: `fault_cause`=01 next cycle, `dp_reset`=1, no `we3` pulse on the faulting cycle, `icount`=2.
- Watchdog (macro on, `WDT_LIMIT`=4), program `J 0` at address 0: FAULT at cycle 5 of RUN, `fault_cause`=10, `icount`=4. With the macro off, still RUN after 100 cycles.
- `reset` mid-run at cycle 3: next cycle IDLE, `icount`=0, `dp_reset`=1, `we3`=0 during the reset cycle.
- From HALTED, hold `start` high for 2 cycles: IDLE then RUN, `icount` cleared, first fetch at PC=0.

Source files
------------

// File: rtl/uc_control.sv
// uc_control: opcode decode plus run/halt/fault sequencing for the single-cycle
// microcontroller datapath. Optional watchdog compiled in with UC_WATCHDOG_EN.
module uc_control #(
  parameter int unsigned WDT_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Opcode,
  input  logic        z,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  Op,
  output logic        dp_reset,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  fault_cause,
  output logic [15:0] icount
);

  localparam int unsigned IcW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_WDT     = 2'b10;

  state_t     state, state_nxt;
  logic       enter_run;
  logic       retire;
  logic       fault_set;
  logic [1:0] fault_nxt;
  logic       wdt_hit;

  // A zero limit would fault before any instruction could run
  if (WDT_LIMIT == 0) begin : g_bad_limit
    $error("uc_control: WDT_LIMIT must be nonzero");
  end

`ifdef UC_WATCHDOG_EN
  localparam int unsigned WdtW = (WDT_LIMIT < 2) ? 1 : $clog2(WDT_LIMIT + 1);

  logic [WdtW-1:0] wdt_cnt;

  assign wdt_hit = (state == S_RUN) && (wdt_cnt == WdtW'(WDT_LIMIT));

  // RUN-cycle counter, restarted on every IDLE->RUN entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if (enter_run) begin
      wdt_cnt <= '0;
    end else if (state == S_RUN && !wdt_hit) begin
      wdt_cnt <= wdt_cnt + WdtW'(1);
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and combinational decode; reset forces safe outputs
  always_comb begin
    state_nxt = state;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    Op        = 3'b000;
    dp_reset  = 1'b1;
    enter_run = 1'b0;
    retire    = 1'b0;
    fault_set = 1'b0;
    fault_nxt = FC_NONE;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        dp_reset = 1'b0;
        if (wdt_hit) begin
          state_nxt = S_FAULT;
          fault_set = 1'b1;
          fault_nxt = FC_WDT;
        end else if (Opcode[5]) begin
          Op     = Opcode[4:2];
          we3    = 1'b1;
          wez    = 1'b1;
          retire = 1'b1;
        end else if (Opcode[4:2] == 3'b000) begin
          we3    = 1'b1;
          s_inm  = 1'b1;
          retire = 1'b1;
        end else if (Opcode[4:2] == 3'b001) begin
          unique case (Opcode[1:0])
            2'b00: begin
              s_inc  = 1'b0;
              retire = 1'b1;
            end
            2'b01: begin
              s_inc  = !z;
              retire = 1'b1;
            end
            2'b10: begin
              s_inc  = z;
              retire = 1'b1;
            end
            default: begin
              s_inc     = 1'b0;
              state_nxt = S_HALTED;
            end
          endcase
        end else begin
          state_nxt = S_FAULT;
          fault_set = 1'b1;
          fault_nxt = FC_ILLEGAL;
        end
      end
      S_HALTED: begin
        dp_reset = 1'b0;
        s_inc    = 1'b0;
        if (start) state_nxt = S_IDLE;
      end
      default: begin
        if (start) state_nxt = S_IDLE;
      end
    endcase

    if (reset) begin
      s_inc    = 1'b1;
      s_inm    = 1'b0;
      we3      = 1'b0;
      wez      = 1'b0;
      Op       = 3'b000;
      dp_reset = 1'b1;
    end

    busy   = (state == S_RUN) && !reset;
    halted = (state == S_HALTED) && !reset;
  end

  // Retired-instruction counter (saturating) and sticky fault cause
  always_ff @(posedge clk) begin
    if (reset) begin
      icount      <= '0;
      fault_cause <= FC_NONE;
    end else begin
      if (enter_run) begin
        icount <= '0;
      end else if (retire && icount != {IcW{1'b1}}) begin
        icount <= icount + IcW'(1);
      end
      if (enter_run) begin
        fault_cause <= FC_NONE;
      end else if (fault_set) begin
        fault_cause <= fault_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uc_control.sv
// Directed bench for uc_control; inputs change on the falling edge and
// outputs are sampled 1 ns later, so every check sees the state left by the
// previous rising edge together with the current opcode.
module tb_uc_control;

  localparam logic [5:0] OP_LI   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [5:0] OP_SUB  = 6'b101000;
  localparam logic [5:0] OP_BAD1 = 6'b010011;
  localparam logic [5:0] OP_BAD2 = 6'b001010;

  logic        clk = 1'b0;
  logic        reset, start, z;
  logic [5:0]  Opcode;
  logic        s_inc, s_inm, we3, wez, dp_reset, busy, halted;
  logic [2:0]  Op;
  logic [1:0]  fault_cause;
  logic [15:0] icount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uc_control #(.WDT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .dp_reset(dp_reset), .busy(busy), .halted(halted),
    .fault_cause(fault_cause), .icount(icount)
  );

  // Count one comparison and report it if it misses
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle's inputs on the falling edge and let decode settle
  task automatic cyc(input logic [5:0] op, input logic zz, input logic st, input logic rs);
    @(negedge clk);
    Opcode = op;
    z      = zz;
    start  = st;
    reset  = rs;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Opcode = OP_LI; z = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dp_reset", 32'(dp_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_s_inc", 32'(s_inc), 32'd1);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_icount", 32'(icount), 32'd0);
    chk("rst_fault", 32'(fault_cause), 32'd0);

    // Program 1: LI, LI, SUB, JZ (taken), HALT
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("idle_we3", 32'(we3), 32'd0);
    chk("idle_dp_reset", 32'(dp_reset), 32'd1);
    cyc(OP_LI, 1'b0, 1'b1, 1'b0);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_dp_reset", 32'(dp_reset), 32'd0);
    chk("li_ctrl", {28'd0, we3, s_inm, wez, s_inc}, 32'b1101);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("li2_icount", 32'(icount), 32'd1);
    cyc(OP_SUB, 1'b0, 1'b0, 1'b0);
    chk("alu_ctrl", {28'd0, we3, s_inm, wez, s_inc}, 32'b1011);
    chk("alu_op", 32'(Op), 32'd2);
    cyc(OP_JZ, 1'b1, 1'b0, 1'b0);
    chk("jz_z1_s_inc", 32'(s_inc), 32'd0);
    chk("jz_we3", 32'(we3), 32'd0);
    cyc(OP_HALT, 1'b1, 1'b0, 1'b0);
    chk("halt_ctrl", {29'd0, we3, wez, s_inc}, 32'b000);
    chk("halt_icount", 32'(icount), 32'd4);

    // HALTED, then start held two cycles: IDLE then RUN
    cyc(OP_HALT, 1'b1, 1'b1, 1'b0);
    chk("halted", 32'(halted), 32'd1);
    chk("halted_busy", 32'(busy), 32'd0);
    chk("halted_dp_s_inc", {30'd0, dp_reset, s_inc}, 32'b00);
    chk("halted_icount", 32'(icount), 32'd4);
    cyc(OP_HALT, 1'b0, 1'b1, 1'b0);
    chk("restart_idle", {29'd0, halted, busy, dp_reset}, 32'b001);
    chk("restart_idle_icount", 32'(icount), 32'd4);

    // Conditional branches in the restarted run
    cyc(OP_JNZ, 1'b1, 1'b0, 1'b0);
    chk("restart_run", {30'd0, busy, dp_reset}, 32'b10);
    chk("restart_icount", 32'(icount), 32'd0);
    chk("jnz_z1_s_inc", 32'(s_inc), 32'd1);
    cyc(OP_JZ, 1'b0, 1'b0, 1'b0);
    chk("jz_z0_s_inc", 32'(s_inc), 32'd1);
    cyc(OP_J, 1'b1, 1'b0, 1'b0);
    chk("j_s_inc", 32'(s_inc), 32'd0);
    cyc(OP_JNZ, 1'b0, 1'b0, 1'b0);
    chk("jnz_z0_s_inc", 32'(s_inc), 32'd0);

    // Reset mid-run gates writes and returns to IDLE
    cyc(OP_LI, 1'b0, 1'b0, 1'b1);
    chk("midrst_ctrl", {28'd0, we3, s_inm, busy, dp_reset}, 32'b0001);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("midrst_idle", {29'd0, busy, halted, dp_reset}, 32'b001);
    chk("midrst_icount", 32'(icount), 32'd0);

    // Illegal opcode at address 2
    cyc(OP_LI, 1'b0, 1'b1, 1'b0);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    cyc(OP_BAD1, 1'b0, 1'b0, 1'b0);
    chk("illegal_ctrl", {28'd0, we3, wez, s_inm, s_inc}, 32'b0001);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("fault_cause_ill", 32'(fault_cause), 32'd1);
    chk("fault_state", {29'd0, busy, dp_reset, we3}, 32'b010);
    chk("fault_icount", 32'(icount), 32'd2);
    cyc(OP_LI, 1'b0, 1'b1, 1'b0);
    cyc(OP_LI, 1'b0, 1'b1, 1'b0);
    chk("fault_idle_hold", 32'(fault_cause), 32'd1);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("fault_cleared", 32'(fault_cause), 32'd0);
    chk("fault_rerun_we3", 32'(we3), 32'd1);
    cyc(OP_BAD2, 1'b0, 1'b0, 1'b0);
    chk("illegal2_we3", 32'(we3), 32'd0);
    cyc(OP_LI, 1'b0, 1'b0, 1'b0);
    chk("fault_cause_ill2", 32'(fault_cause), 32'd1);
    chk("fault2_icount", 32'(icount), 32'd1);

    // Self-loop J 0: watchdog fault or unbounded RUN
    cyc(OP_J, 1'b0, 1'b1, 1'b0);
    cyc(OP_J, 1'b0, 1'b1, 1'b0);
`ifdef UC_WATCHDOG_EN
    for (int i = 0; i < 8; i++) begin
      cyc(OP_J, 1'b0, 1'b0, 1'b0);
      chk("wdt_loop_s_inc", 32'(s_inc), 32'd0);
    end
    cyc(OP_J, 1'b0, 1'b0, 1'b0);
    chk("wdt_hit_ctrl", {29'd0, we3, wez, s_inc}, 32'b001);
    cyc(OP_J, 1'b0, 1'b0, 1'b0);
    chk("wdt_fault_cause", 32'(fault_cause), 32'd2);
    chk("wdt_icount", 32'(icount), 32'd8);
    chk("wdt_busy", 32'(busy), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      cyc(OP_J, 1'b0, 1'b0, 1'b0);
      chk("loop_s_inc", 32'(s_inc), 32'd0);
    end
    cyc(OP_J, 1'b0, 1'b0, 1'b0);
    chk("loop_busy", 32'(busy), 32'd1);
    chk("loop_icount", 32'(icount), 32'd100);
    chk("loop_fault", 32'(fault_cause), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
